pic_priority_resolver: RTL
==========================

# pic_priority_resolver

Synchronous priority resolver and in-service tracker for the 8259A PIC. It sits directly upstream of the control logic and owns the ISR. It qualifies pending IRR bits against IMR and the current in-service level, then raises `int_request` with the winning `interrupt_index`. It sets ISR on the first INTA acknowledge and clears ISR on EOI commands decoded from OCW2.

## Interface
Parameters:
- `NUM_IR`, 8, number of interrupt lines; only 8 is supported.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `irr`  in  8  pending requests from the IRR.
- `imr`  in  8  mask bits; 1 = masked.
- `ack1`  in  1  one-cycle strobe for the first INTA pulse.
- `ack2`  in  1  one-cycle strobe for the second INTA pulse.
- `eoi_ns`  in  1  one-cycle strobe for a non-specific EOI.
- `eoi_sp`  in  1  one-cycle strobe for a specific EOI.
- `eoi_level`  in  3  level for `eoi_sp` and `set_prio`.
- `rotate`  in  1  OCW2 R bit; qualifies `eoi_ns`.
- `set_prio`  in  1  one-cycle strobe: make `eoi_level` the lowest priority.
- `int_request`  out  1  request to the control logic.
- `interrupt_index`  out  3  winning IR number.
- `isr`  out  8  in-service register.
- `clear_irr`  out  8  one-hot, one-cycle strobe that clears the acknowledged IRR bit.
- `spurious`  out  1  one-cycle flag: `ack1` arrived with no valid request.

## Operation
- Priority rank of IR i = (i − lp − 1) mod 8. Rank 0 is highest. `lp` is the 3-bit lowest-priority pointer; its reset value is 7, so IR0 is highest.
- Candidate set = `irr & ~imr`. The winner is the candidate with the lowest rank.
- The winner is valid only if its rank is strictly lower than the rank of the highest-priority set `isr` bit (fully nested). If `isr` is 0, any candidate is valid.
- FSM states:
  - IDLE:
    - A valid winner exists → REQ.
    - `int_request` is 0.
  - REQ:
    - `int_request` is 1; `interrupt_index` tracks the winner each cycle.
    - Valid winner disappears → IDLE.
    - `ack1` → ACK.
  - ACK:
    - `interrupt_index` is frozen and `int_request` is 0.
    - `ack2` → IDLE.
- On `ack1` in REQ:
  - `isr[idx]` is set.
  - `clear_irr[idx]` pulses.
  - `interrupt_index` is frozen.
- On `ack1` in IDLE:
  - `spurious` pulses.
  - `interrupt_index` = 7.
  - The FSM enters ACK.
  - `isr` is unchanged.
- Ignored strobes: `ack1` in ACK and `ack2` in IDLE/REQ.
- EOI commands:
  - `eoi_ns` clears the highest-priority set `isr` bit. It does nothing if `isr` is 0.
  - `eoi_sp` clears `isr[eoi_level]`.
  - If `eoi_ns` and `eoi_sp` arrive together, `eoi_sp` wins.
- EOI coincident with `ack1`: the EOI clear uses the pre-update `isr`. The new bit is set in the same edge and is never cleared by that EOI.
- Valid-winner evaluation uses registered `isr`. A newly cleared level can request from the cycle after the EOI.
- Reset (at any point, including mid-handshake):
  - FSM → IDLE.
  - `isr`=0, `lp`=7, `interrupt_index`=0.
  - `int_request`=0, `clear_irr`=0, `spurious`=0.

## Timing
- All outputs are registered.
- A qualifying request sampled at edge N gives `int_request`=1 after edge N+1 (latency 1).
- `ack1` sampled at edge N:
  - `isr`, `clear_irr`, `spurious` and `int_request`=0 are all visible after edge N.
  - `clear_irr` and `spurious` are high for exactly one cycle.
- `ack2` at edge N: FSM is IDLE after N. The next request is asserted no earlier than after N+1.
- EOI at edge N: `isr` is updated after N.
- `interrupt_index` is held constant from `ack1` until the edge after `ack2`.

## Configuration
- Macro: `PIC_ROTATION_EN`.
- Defined:
  - `eoi_ns` with `rotate`=1 sets `lp` to the cleared level; no change if `isr` was 0.
  - `eoi_sp` with `rotate`=1 sets `lp` to `eoi_level`.
  - `set_prio` sets `lp` to `eoi_level`.
  - A rotation coincident with `ack1` takes effect for the next arbitration.
- Undefined:
  - `lp` is constant 7.
  - `rotate` and `set_prio` are ignored.
  - EOI behaviour is otherwise identical.

## Test plan
- Reset, `irr`=8'h28, `imr`=0 → `int_request`=1 after 1 cycle with `interrupt_index`=3. `ack1` → `isr`=8'h08, `clear_irr`=8'h08 for 1 cycle. `ack2` → IDLE.
- `isr`=8'h08, `irr`=8'h20 → no request. Then `irr`=8'h02 → request with index 1 (nesting). `eoi_ns` → clears `isr` bit 1 first, leaving 8'h08.
- `irr`=8'h10 with request raised, `irr`→0 before `ack1`, then `ack1` → `int_request` drops, `spurious`=1, `interrupt_index`=7, `isr` unchanged.
- `imr`=8'hFF with `irr`=8'hFF → no request ever. Clear `imr[6]` → index 6.
- With `PIC_ROTATION_EN`: `isr`=8'h01, `eoi_ns`+`rotate` → `lp`=0. Then `irr`=8'h81 → index 7. Without the macro, the same stimulus gives index 0.
- `rst_n`=0 during ACK → all outputs reset next edge. `ack2` afterwards is ignored.

Source files
------------

// File: rtl/pic_priority_resolver.sv
// 8259A priority resolver and in-service tracker: IRR/IMR arbitration, ISR ownership,
// INTA handshake FSM and EOI handling. Optional priority rotation under PIC_ROTATION_EN.
module pic_priority_resolver #(
  parameter int NUM_IR = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IR-1:0] irr,
  input  logic [NUM_IR-1:0] imr,
  input  logic              ack1,
  input  logic              ack2,
  input  logic              eoi_ns,
  input  logic              eoi_sp,
  input  logic [2:0]        eoi_level,
  input  logic              rotate,
  input  logic              set_prio,
  output logic              int_request,
  output logic [2:0]        interrupt_index,
  output logic [NUM_IR-1:0] isr,
  output logic [NUM_IR-1:0] clear_irr,
  output logic              spurious
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]        lp;
  logic [NUM_IR-1:0] cand;

  logic              win_any;
  logic [2:0]        win_idx;
  logic [2:0]        win_rank;
  logic              isr_any;
  logic [2:0]        isr_idx;
  logic [2:0]        isr_rank;
  logic              valid;

  logic              ack_take;
  logic [NUM_IR-1:0] ack_set;
  logic [NUM_IR-1:0] eoi_clr;

  logic              req_nxt;
  logic [2:0]        idx_nxt;
  logic [NUM_IR-1:0] isr_nxt;
  logic [NUM_IR-1:0] clr_nxt;
  logic              spur_nxt;

  // IR level that holds a given rank; rank 0 sits just above the lowest-priority pointer.
  function automatic logic [2:0] level_at(input logic [2:0] lowest, input logic [2:0] rank);
    return lowest + rank + 3'd1;
  endfunction

  assign cand = irr & ~imr;

  // Scanning from the lowest rank upward lets the highest-priority hit overwrite the others.
  // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    win_any  = 1'b0;
    win_idx  = 3'd0;
    win_rank = 3'd0;
    isr_any  = 1'b0;
    isr_idx  = 3'd0;
    isr_rank = 3'd0;
    for (int r = 7; r >= 0; r--) begin
      if (cand[level_at(lp, 3'(r))]) begin
        win_any  = 1'b1;
        win_idx  = level_at(lp, 3'(r));
        win_rank = 3'(r);
      end
      if (isr[level_at(lp, 3'(r))]) begin
        isr_any  = 1'b1;
        isr_idx  = level_at(lp, 3'(r));
        isr_rank = 3'(r);
      end
    end
  end

  // Fully nested mode: a winner must outrank every level already in service.
  assign valid = win_any && (!isr_any || (win_rank < isr_rank));

  assign ack_take = ack1 && (state == REQ) && valid;

  always_comb begin
    ack_set = '0;
    if (ack_take) ack_set[win_idx] = 1'b1;
  end

  // EOI works on the registered ISR, so a level set by a coincident ack1 is never cleared.
  always_comb begin
    eoi_clr = '0;
    if (eoi_sp)                  eoi_clr[eoi_level] = 1'b1;
    else if (eoi_ns && isr_any)  eoi_clr[isr_idx]   = 1'b1;
  end

  assign isr_nxt = (isr & ~eoi_clr) | ack_set;

`ifdef PIC_ROTATION_EN
  logic [2:0] lp_nxt;

  always_comb begin
    lp_nxt = lp;
    if (eoi_sp && rotate)                 lp_nxt = eoi_level;
    else if (eoi_ns && rotate && isr_any) lp_nxt = isr_idx;
    else if (set_prio)                    lp_nxt = eoi_level;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lp <= 3'd7;
    else        lp <= lp_nxt;
  end
`else
  logic unused_rotation;

  assign lp              = 3'd7;
  assign unused_rotation = ^{rotate, set_prio};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (ack1)       state_nxt = ACK;
            else if (valid) state_nxt = REQ;
      REQ:  if (ack1)       state_nxt = ACK;
            else if (!valid) state_nxt = IDLE;
      ACK:  if (ack2)       state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; the index freezes for the whole ACK state.
  always_comb begin
    spur_nxt = ack1 && ((state == IDLE) || ((state == REQ) && !valid));
    req_nxt  = (state == REQ) && valid && !ack1;
    clr_nxt  = ack_set;
    idx_nxt  = interrupt_index;
    if (spur_nxt)                     idx_nxt = 3'd7;
    else if ((state != ACK) && valid) idx_nxt = win_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int_request     <= 1'b0;
      interrupt_index <= 3'd0;
      isr             <= '0;
      clear_irr       <= '0;
      spurious        <= 1'b0;
    end else begin
      int_request     <= req_nxt;
      interrupt_index <= idx_nxt;
      isr             <= isr_nxt;
      clear_irr       <= clr_nxt;
      spurious        <= spur_nxt;
    end
  end

endmodule
